// File: rtl/control_mult_if.sv
// ----------------------------------------------------------------------------
// control_mult_if
//   Bundle of the signals that control_mult exchanges with the rest of the
//   datapath.
//   Sequencer side:
//     i_start          start request (sampled only while the controller idles)
//     i_multiplicando  multiplicand, captured when start is accepted
//     i_multiplicador  multiplier, captured when start is accepted
//     o_producto       2N-bit product, held until the next completion
//     o_done           one-cycle completion pulse
//     o_busy           high whenever the controller is not idle
//   ALU side (controller is the initiator):
//     o_alu_a, o_alu_b, o_alu_control  operands and operation code
//     i_alu_q, i_alu_mayor, i_alu_paridad  result, add carry-out, result bit 0
//   Modports:
//     master  the multiplier controller
//     slave   the environment (sequencer plus ALU)
// ----------------------------------------------------------------------------
interface control_mult_if #(
    parameter int N = 16
);
    logic             i_start;
    logic [N-1:0]     i_multiplicando;
    logic [N-1:0]     i_multiplicador;
    logic [2*N-1:0]   o_producto;
    logic             o_done;
    logic             o_busy;
    logic [N-1:0]     o_alu_a;
    logic [N-1:0]     o_alu_b;
    logic [2:0]       o_alu_control;
    logic [N-1:0]     i_alu_q;
    logic             i_alu_mayor;
    logic             i_alu_paridad;

    modport master (
        input  i_start, i_multiplicando, i_multiplicador,
        input  i_alu_q, i_alu_mayor, i_alu_paridad,
        output o_producto, o_done, o_busy,
        output o_alu_a, o_alu_b, o_alu_control
    );

    modport slave (
        output i_start, i_multiplicando, i_multiplicador,
        output i_alu_q, i_alu_mayor, i_alu_paridad,
        input  o_producto, o_done, o_busy,
        input  o_alu_a, o_alu_b, o_alu_control
    );
endinterface

// File: rtl/control_mult.sv
// ----------------------------------------------------------------------------
// control_mult
//   Sequential shift-and-add unsigned multiplier controller. All arithmetic is
//   done by an external ALU; this block only sequences it. Each multiplier bit
//   takes three cycles (PRUEBA -> SUMA -> DESPLAZA), so a product takes 3N
//   cycles from the accepting edge to the done pulse.
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset
//     bus      control_mult_if.master (sequencer handshake + ALU drive)
//   N must match the attached ALU's operand width.
// ----------------------------------------------------------------------------
module control_mult #(
    parameter int N = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    control_mult_if.master     bus
);
    localparam int CW = $clog2(N + 1);

    // ALU operation codes; subtraction (3'b010) is never issued.
    localparam logic [2:0] ALU_SUMA   = 3'b000;
    localparam logic [2:0] ALU_DESP_D = 3'b001;
    localparam logic [2:0] ALU_PASA   = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRUEBA,
        S_SUMA,
        S_DESPLAZA,
        S_FIN
    } state_t;

    state_t            state, state_next;
    logic [N-1:0]      m;        // multiplicand
    logic [N-1:0]      acc;      // high half of the running product
    logic [N-1:0]      q;        // multiplier, shifted out as product low half
    logic              c;        // carry out of the last add
    logic              p;        // multiplier bit under test
    logic [CW-1:0]     cnt;      // iterations remaining
    logic [2*N-1:0]    producto;
    logic              done;

    // Values the accumulator pair takes at the end of DESPLAZA. The ALU has
    // already shifted acc right, so the captured carry fills the vacated MSB.
    logic [N-1:0]      acc_sh;
    logic [N-1:0]      q_sh;

    assign acc_sh = {c, bus.i_alu_q[N-2:0]};
    assign q_sh   = {acc[0], q[N-1:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first means every path assigns
    // state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.i_start) state_next = S_PRUEBA;
            S_PRUEBA:   state_next = S_SUMA;
            S_SUMA:     state_next = S_DESPLAZA;
            S_DESPLAZA: state_next = (cnt == CW'(1)) ? S_FIN : S_PRUEBA;
            S_FIN:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: ALU drive is a pure function of the state
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_alu_a       = '0;
        bus.o_alu_b       = '0;
        bus.o_alu_control = ALU_PASA;
        case (state)
            S_PRUEBA: begin
                // Pass Q through so the ALU reports its LSB on paridad.
                bus.o_alu_a = q;
            end
            S_SUMA: begin
                // Always add, zero when the bit is clear, so latency is fixed.
                bus.o_alu_a       = acc;
                bus.o_alu_b       = p ? m : '0;
                bus.o_alu_control = ALU_SUMA;
            end
            S_DESPLAZA: begin
                bus.o_alu_a       = acc;
                bus.o_alu_control = ALU_DESP_D;
            end
            default: ;
        endcase
    end

    assign bus.o_busy     = (state != S_IDLE);
    assign bus.o_done     = done;
    assign bus.o_producto = producto;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m        <= '0;
            acc      <= '0;
            q        <= '0;
            c        <= 1'b0;
            p        <= 1'b0;
            cnt      <= '0;
            producto <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        m   <= bus.i_multiplicando;
                        q   <= bus.i_multiplicador;
                        acc <= '0;
                        c   <= 1'b0;
                        cnt <= CW'(N);
                    end
                end
                S_PRUEBA: begin
                    p <= bus.i_alu_paridad;
                end
                S_SUMA: begin
                    acc <= bus.i_alu_q;
                    c   <= bus.i_alu_mayor;
                end
                S_DESPLAZA: begin
                    acc <= acc_sh;
                    q   <= q_sh;
                    c   <= 1'b0;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        producto <= {acc_sh, q_sh};
                        done     <= 1'b1;
                    end
                end
                S_FIN: begin
                    done <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_mult.sv
// ----------------------------------------------------------------------------
// tb_control_mult
//   Self-checking bench for control_mult. A behavioural ALU closes the loop;
//   expected products come from plain multiplication and the expected ALU
//   command stream from the three-cycles-per-multiplier-bit schedule.
// ----------------------------------------------------------------------------
module tb_control_mult;
    localparam int N   = 16;
    localparam int LAT = 3 * N;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    control_mult_if #(.N(N)) bus ();

    control_mult #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [N:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (bus.o_alu_control)
            3'b000:  alu_full = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
            3'b001:  alu_full = {1'b0, bus.o_alu_a >> 1};
            3'b010:  alu_full = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
            3'b011:  alu_full = {1'b0, bus.o_alu_a};
            default: alu_full = '0;
        endcase
        bus.i_alu_q       = alu_full[N-1:0];
        bus.i_alu_mayor   = (bus.o_alu_control == 3'b000) ? alu_full[N] : 1'b0;
        bus.i_alu_paridad = alu_full[0];
    end

    // Runs one multiply starting at the current negedge. Observes the DUT
    // from the accepting edge through one cycle past the expected done, and
    // reports what it saw. The ALU command stream is compared against the
    // schedule: cycle j after acceptance is PASA/SUMA/DESP_D for j%3=0/1/2,
    // and during the SUMA of iteration k the B operand must be the
    // multiplicand only when multiplier bit k is set.
    task automatic run_mult(
        input  logic [N-1:0]   a,
        input  logic [N-1:0]   b,
        input  int             extra_at,
        input  logic [N-1:0]   xa,
        input  logic [N-1:0]   xb,
        output logic [2*N-1:0] prod_at_done,
        output logic [2*N-1:0] prod_before,
        output bit             changed_early,
        output int             done_cycle,
        output int             done_count,
        output int             busy_count,
        output int             seq_errs
    );
        logic [2:0]   exp_ctrl;
        logic [N-1:0] exp_b;
        prod_at_done  = '0;
        prod_before   = '0;
        changed_early = 1'b0;
        done_cycle    = -1;
        done_count    = 0;
        busy_count    = 0;
        seq_errs      = 0;
        bus.i_start         = 1'b1;
        bus.i_multiplicando = a;
        bus.i_multiplicador = b;
        @(posedge clk);
        @(negedge clk);
        bus.i_start         = 1'b0;
        bus.i_multiplicando = N'($urandom);
        bus.i_multiplicador = N'($urandom);
        for (int j = 0; j <= LAT + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.o_busy === 1'b1) busy_count++;
            if (bus.o_done === 1'b1) begin
                done_count++;
                done_cycle   = j;
                prod_at_done = bus.o_producto;
            end
            if (j == 0) prod_before = bus.o_producto;
            else if (j < LAT && bus.o_producto !== prod_before) changed_early = 1'b1;
            exp_ctrl = 3'b011;
            exp_b    = '0;
            if (j < LAT) begin
                case (j % 3)
                    1: begin
                        exp_ctrl = 3'b000;
                        exp_b    = b[j/3] ? a : '0;
                    end
                    2: exp_ctrl = 3'b001;
                    default: exp_ctrl = 3'b011;
                endcase
            end
            if (bus.o_alu_control !== exp_ctrl || bus.o_alu_b !== exp_b) seq_errs++;
            bus.i_start = (j == extra_at);
            if (j == extra_at) begin
                bus.i_multiplicando = xa;
                bus.i_multiplicador = xb;
            end
        end
        bus.i_start = 1'b0;
    endtask

    // Scratch results shared by the scenario tasks (only one runs at a time)
    logic [2*N-1:0] r_prod, r_before;
    bit             r_changed;
    int             r_dcyc, r_dcnt, r_busy, r_seq;

    task automatic test_reset();
        rst_n               = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_multiplicando = '0;
        bus.i_multiplicador = '0;
        #3;
        vectors++;
        if (bus.o_producto !== '0) begin
            miscompares++;
            $display("FAIL reset_producto: got %0h expected 0", bus.o_producto);
        end
        vectors++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got done=%b busy=%b expected 0/0", bus.o_done, bus.o_busy);
        end
        vectors++;
        if (bus.o_alu_control !== 3'b011 || bus.o_alu_a !== '0 || bus.o_alu_b !== '0) begin
            miscompares++;
            $display("FAIL reset_alu_drive: got ctrl=%b a=%0h b=%0h expected 011/0/0",
                     bus.o_alu_control, bus.o_alu_a, bus.o_alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_mult(16'd3, 16'd5, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'h0000000F) begin
            miscompares++;
            $display("FAIL basic_product: got %0h expected f", r_prod);
        end
        vectors++;
        if (r_dcyc !== LAT || r_dcnt !== 1) begin
            miscompares++;
            $display("FAIL basic_done: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1", r_dcyc, r_dcnt, LAT);
        end
        vectors++;
        if (r_busy !== LAT + 1) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d expected %0d", r_busy, LAT + 1);
        end
        vectors++;
        if (r_seq !== 0) begin
            miscompares++;
            $display("FAIL basic_alu_sequence: got %0d bad cycles expected 0", r_seq);
        end
    endtask

    task automatic test_carry();
        run_mult(16'hFFFF, 16'hFFFF, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'hFFFE0001) begin
            miscompares++;
            $display("FAIL carry_product: got %0h expected fffe0001", r_prod);
        end
        vectors++;
        if (r_seq !== 0) begin
            miscompares++;
            $display("FAIL carry_alu_sequence: got %0d bad cycles expected 0", r_seq);
        end
    endtask

    task automatic test_zero_identity();
        logic [N-1:0]   ta [3];
        logic [N-1:0]   tb [3];
        logic [2*N-1:0] te [3];
        ta = '{16'h0000, 16'h1234, 16'h8000};
        tb = '{16'h1234, 16'h0001, 16'h0002};
        te = '{32'h00000000, 32'h00001234, 32'h00010000};
        for (int i = 0; i < 3; i++) begin
            run_mult(ta[i], tb[i], -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
            vectors++;
            if (r_prod !== te[i] || r_dcnt !== 1) begin
                miscompares++;
                $display("FAIL zero_identity_%0d: got %0h (pulses %0d) expected %0h", i, r_prod, r_dcnt, te[i]);
            end
            vectors++;
            if (r_seq !== 0) begin
                miscompares++;
                $display("FAIL zero_identity_seq_%0d: got %0d bad cycles expected 0", i, r_seq);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int extra_done;
        int extra_busy;
        run_mult(16'd7, 16'd9, 10, 16'h1111, 16'h0003, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'h0000003F || r_dcnt !== 1 || r_dcyc !== LAT) begin
            miscompares++;
            $display("FAIL busy_start_product: got %0h pulses=%0d cycle=%0d expected 3f/1/%0d",
                     r_prod, r_dcnt, r_dcyc, LAT);
        end
        extra_done = 0;
        extra_busy = 0;
        for (int j = 0; j < LAT + 4; j++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) extra_done++;
            if (bus.o_busy === 1'b1) extra_busy++;
        end
        vectors++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            miscompares++;
            $display("FAIL busy_start_dropped: got done=%0d busy=%0d cycles expected 0/0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_mid_op();
        bus.i_start         = 1'b1;
        bus.i_multiplicando = 16'hABCD;
        bus.i_multiplicador = 16'h1357;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_producto !== '0) begin
            miscompares++;
            $display("FAIL midop_reset: got busy=%b done=%b prod=%0h expected 0/0/0",
                     bus.o_busy, bus.o_done, bus.o_producto);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mult(16'd2, 16'd2, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'h00000004 || r_dcnt !== 1) begin
            miscompares++;
            $display("FAIL midop_recover: got %0h pulses=%0d expected 4/1", r_prod, r_dcnt);
        end
    endtask

    task automatic test_back_to_back();
        run_mult(16'd6, 16'd7, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'h0000002A) begin
            miscompares++;
            $display("FAIL b2b_first: got %0h expected 2a", r_prod);
        end
        // run_mult returns one cycle after done, so this start is sampled
        // exactly two cycles after the done pulse.
        run_mult(16'h00FF, 16'h0101, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
        vectors++;
        if (r_prod !== 32'h0000FFFF || r_dcyc !== LAT) begin
            miscompares++;
            $display("FAIL b2b_second: got %0h cycle=%0d expected ffff/%0d", r_prod, r_dcyc, LAT);
        end
        vectors++;
        if (r_before !== 32'h0000002A || r_changed) begin
            miscompares++;
            $display("FAIL b2b_hold: got %0h changed=%0b expected 2a held", r_before, r_changed);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   a, b;
        logic [2*N-1:0] expected;
        for (int i = 0; i < 10; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if (i == 0) a = 16'hFFFF;
            expected = (2*N)'(a) * (2*N)'(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_mult(a, b, -1, '0, '0, r_prod, r_before, r_changed, r_dcyc, r_dcnt, r_busy, r_seq);
            vectors++;
            if (r_prod !== expected || r_dcnt !== 1 || r_dcyc !== LAT) begin
                miscompares++;
                $display("FAIL random_%0d %0h*%0h: got %0h pulses=%0d cycle=%0d expected %0h",
                         i, a, b, r_prod, r_dcnt, r_dcyc, expected);
            end
            vectors++;
            if (r_seq !== 0) begin
                miscompares++;
                $display("FAIL random_seq_%0d: got %0d bad cycles expected 0", i, r_seq);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero_identity();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/control_mult.md
Name: control_mult

Overview:
- Sequential shift-and-add multiplier controller. It is the initiator side of the ALU operand/control interface.
- It drives the ALU's operand A, operand B and 3-bit control inputs, and consumes the ALU result, carry flag ("mayor") and LSB flag ("paridad").
- It forms a 2N-bit unsigned product over 3N cycles, with a start/done handshake toward the datapath sequencer.

Parameters:
- N, 16, operand width. Must equal the attached ALU's N; the ALU carry flag is valid only for N=16.

Ports:
- i_clk  input  1  system clock; rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low. One clock domain only.
- i_start  input  1  start request; sampled only in IDLE.
- i_multiplicando  input  N  multiplicand; captured when start is accepted.
- i_multiplicador  input  N  multiplier; captured when start is accepted.
- o_producto  output  2N  product; registered; held until the next completion.
- o_done  output  1  one-cycle completion pulse.
- o_busy  output  1  high in every state except IDLE.
- o_alu_a  output  N  to ALU i_a.
- o_alu_b  output  N  to ALU i_b.
- o_alu_control  output  3  to ALU i_control; bit 2 always 0.
- i_alu_q  input  N  ALU result.
- i_alu_mayor  input  1  ALU carry-out of an add.
- i_alu_paridad  input  1  ALU result bit 0.

Behaviour:
- ALU codes:
  - SUMA = 3'b000
  - DESP_D (A>>1) = 3'b001
  - PASA (result = A) = 3'b011
  - RESTA 3'b010 is never issued.
- Internal registers: M (N), A accumulator (N), Q (N), C carry (1), p tested bit (1), cnt ($clog2(N+1) bits).
- Reset (async, i_rst_n=0): state=IDLE; o_producto=0; o_done=0; o_busy=0; M=A=Q=0; C=0; p=0; cnt=0. Reset mid-operation abandons the multiply with no done pulse; o_producto returns to 0.
- ALU drive is combinational from state:
  - IDLE/FIN: a=0, b=0, ctrl=PASA.
  - PRUEBA: a=Q, b=0, ctrl=PASA.
  - SUMA: a=A, b=(p ? M : 0), ctrl=SUMA.
  - DESPLAZA: a=A, b=0, ctrl=DESP_D.
- FSM transitions (all at rising edge):
  - IDLE: if i_start: M<=i_multiplicando, Q<=i_multiplicador, A<=0, C<=0, cnt<=N; go to PRUEBA. Otherwise stay.
  - PRUEBA: p<=i_alu_paridad (= Q[0]); go to SUMA.
  - SUMA: A<=i_alu_q; C<=i_alu_mayor. This state always executes, adding 0 when p=0, so latency is fixed; go to DESPLAZA.
  - DESPLAZA:
    - A<={C, i_alu_q[N-2:0]}; Q<={A[0], Q[N-1:1]}; C<=0; cnt<=cnt-1.
    - If cnt==1: o_producto<={new A, new Q}, o_done<=1, go to FIN. Otherwise go to PRUEBA.
  - FIN: o_done<=0; go to IDLE. i_start is ignored in FIN.
- Latency: start sampled at edge t, so o_done is high between edges t+3N and t+3N+1 (48 cycles for N=16).
- Earliest next start is sampled at edge t+3N+2.
- i_start in any state other than IDLE is ignored; operands are not recaptured.
- Arithmetic is unsigned. C captures the add carry so the full 2N-bit product is exact; no overflow is possible.
- An operand change after acceptance has no effect.
- o_busy=1 in PRUEBA, SUMA, DESPLAZA and FIN.

Test Plan:
- Basic multiply: N=16, bench ALU instance connected; start with 3 × 5. Required: o_producto=32'h0000000F; o_done is a single pulse 48 cycles after the start edge; o_busy high for 49 cycles.
- Carry path: 16'hFFFF × 16'hFFFF. Required: o_producto=32'hFFFE0001; C is captured as 1 on SUMA cycles where the add overflows.
- Zero and identity:
  - 0 × 16'h1234 gives 0.
  - 16'h1234 × 1 gives 32'h00001234.
  - 16'h8000 × 2 gives 32'h00010000.
  - In every case, o_alu_control sequences 011, 000, 001 × 16 and o_alu_b=0 whenever p=0.
- Start while busy: pulse i_start with new operands at cycle 10 of a 7 × 9 run. Required: result is 32'h0000003F; the second request is dropped; no extra done pulse.
- Reset mid-operation: assert i_rst_n=0 asynchronously at cycle 20, between clock edges. Required: o_busy, o_done and o_producto go to 0 immediately; after release, 2 × 2 completes with 32'h00000004.
- Back-to-back: start 6 × 7, then start 16'h00FF × 16'h0101 exactly 2 cycles after the done pulse. Required: 32'h0000002A, then 32'h0000FFFF; o_producto holds 32'h0000002A until the second done pulse.
